// File: rtl/bnn_layer_seq.sv
// Time-multiplexed binary neural network layer: one XNOR-popcount-threshold neuron per cycle.
// Define BNN_THR_PROG_EN to add per-neuron programmable thresholds (thr_wr_en port).
module bnn_layer_seq #(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 8,
    parameter int THRESH = N_IN / 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
`ifdef BNN_THR_PROG_EN
    input  logic                       thr_wr_en,
`endif
    input  logic [$clog2(N_OUT)-1:0]   wr_addr,
    input  logic [N_IN-1:0]            wr_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_IN-1:0]            in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_OUT-1:0]           out_data,
    output logic                       busy
);

    localparam int CW = $clog2(N_IN + 1);
    localparam int NW = $clog2(N_OUT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       r_state;
    logic [N_IN-1:0]  r_x;
    logic [NW-1:0]    r_n;
    logic [N_OUT-1:0] r_result;
    logic [N_OUT-1:0] r_out_data;
    logic [N_IN-1:0]  r_w [N_OUT];
`ifdef BNN_THR_PROG_EN
    logic [CW-1:0]    r_thr [N_OUT];
`endif

    logic [N_IN-1:0]  w_match;
    logic [CW-1:0]    w_pop;
    logic [31:0]      w_thr;
    logic             w_act;
    logic             w_last;
    logic [N_OUT-1:0] w_result_next;

    // Evaluation reads the registered row, so a same-cycle write to that row is not seen.
    always_comb begin
        w_match = ~(r_x ^ r_w[r_n]);
        w_pop   = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            w_pop = w_pop + CW'(w_match[i]);
        end
`ifdef BNN_THR_PROG_EN
        w_thr = 32'(r_thr[r_n]);
`else
        w_thr = 32'(THRESH);
`endif
        w_act         = (32'(w_pop) >= w_thr);
        w_last        = (r_n == NW'(N_OUT - 1));
        w_result_next = r_result;
        w_result_next[r_n] = w_act;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_n        <= '0;
            r_result   <= '0;
            r_out_data <= '0;
            for (int unsigned i = 0; i < N_OUT; i++) begin
                r_w[i] <= '0;
`ifdef BNN_THR_PROG_EN
                r_thr[i] <= CW'(THRESH);
`endif
            end
        end else begin
            // Address decode per row: addresses at or beyond N_OUT match no row.
            for (int unsigned i = 0; i < N_OUT; i++) begin
                if (wr_en && (wr_addr == NW'(i))) begin
                    r_w[i] <= wr_data;
                end
`ifdef BNN_THR_PROG_EN
                if (thr_wr_en && (wr_addr == NW'(i))) begin
                    r_thr[i] <= wr_data[CW-1:0];
                end
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x      <= in_data;
                        r_n      <= '0;
                        r_result <= '0;
                        r_state  <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_result <= w_result_next;
                    if (w_last) begin
                        r_out_data <= w_result_next;
                        r_n        <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_n <= r_n + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed bench for bnn_layer_seq: three instances share stimulus (default 8x8,
// THRESH=7 variant, and N_OUT=6 variant for out-of-range row addresses).
module tb_bnn_layer_seq;

`ifdef BNN_THR_PROG_EN
    localparam bit THR_PROG = 1'b1;
`else
    localparam bit THR_PROG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       thr_wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready,  out_valid,  busy;
    logic [7:0] out_data;
    logic       in_ready7, out_valid7, busy7;
    logic [7:0] out_data7;
    logic       in_ready6, out_valid6, busy6;
    logic [5:0] out_data6;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int lat;

    always #5 clk = ~clk;

    bnn_layer_seq #(.N_IN(8), .N_OUT(8), .THRESH(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en),
`ifdef BNN_THR_PROG_EN
        .thr_wr_en(thr_wr_en),
`endif
        .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    bnn_layer_seq #(.N_IN(8), .N_OUT(8), .THRESH(7)) dut7 (
        .clk(clk), .reset(reset), .wr_en(wr_en),
`ifdef BNN_THR_PROG_EN
        .thr_wr_en(thr_wr_en),
`endif
        .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready7), .in_data(in_data),
        .out_valid(out_valid7), .out_ready(out_ready), .out_data(out_data7), .busy(busy7)
    );

    bnn_layer_seq #(.N_IN(8), .N_OUT(6), .THRESH(4)) dut6 (
        .clk(clk), .reset(reset), .wr_en(wr_en),
`ifdef BNN_THR_PROG_EN
        .thr_wr_en(thr_wr_en),
`endif
        .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data),
        .out_valid(out_valid6), .out_ready(out_ready), .out_data(out_data6), .busy(busy6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic accept(input logic [7:0] x);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n++;
            if (out_valid) break;
        end
        chk({tag, " done"}, 32'(out_valid), 32'd1);
    endtask

    // Full transaction with out_ready high: accept, wait, check results, handshake.
    task automatic run(input string tag, input logic [7:0] x,
                       input logic [7:0] e8, input logic [7:0] e7, input logic [5:0] e6);
        int n;
        accept(x);
        wait_done(tag, n);
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " out"},  32'(out_data),  32'(e8));
        chk({tag, " out7"}, 32'(out_data7), 32'(e7));
        chk({tag, " out6"}, 32'(out_data6), 32'(e6));
        tick();
        chk({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        thr_wr_en = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data",  32'(out_data),  32'd0);
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst busy",      32'(busy),      32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Weights zero after reset
        run("zero w x00", 8'h00, 8'hFF, 8'hFF, 6'h3F);
        run("zero w xFF", 8'hFF, 8'h00, 8'h00, 6'h00);

        // All rows FF; rows 6,7 are out of range for the 6-neuron instance
        for (int i = 0; i < 8; i++) write_row(3'(i), 8'hFF);
        accept(8'hF0);
        chk("compute busy",     32'(busy),     32'd1);
        chk("compute in_ready", 32'(in_ready), 32'd0);
        chk("compute out_valid", 32'(out_valid), 32'd0);
        wait_done("allFF xF0", lat);
        chk("allFF xF0 latency", 32'(lat), 32'd8);
        chk("allFF xF0 out",  32'(out_data),  32'hFF);
        chk("allFF xF0 out7", 32'(out_data7), 32'h00);
        chk("allFF xF0 out6", 32'(out_data6), 32'h3F);
        tick();
        chk("allFF hs in_ready", 32'(in_ready), 32'd1);
        run("allFF x70", 8'h70, 8'h00, 8'h00, 6'h00);

        // One-hot rows
        for (int i = 0; i < 8; i++) write_row(3'(i), 8'(1 << i));
        run("onehot x01", 8'h01, 8'hFF, 8'h01, 6'h3F);

        // Backpressure
        out_ready = 1'b0;
        accept(8'h01);
        wait_done("bp", lat);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h70;
            tick();
            chk("bp out_data7 stable", 32'(out_data7), 32'h01);
            chk("bp out_valid",        32'(out_valid), 32'd1);
            chk("bp in_ready",         32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp release in_ready",  32'(in_ready),  32'd1);
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release busy",      32'(busy),      32'd0);
        chk("bp idle holds out7",   32'(out_data7), 32'h01);

        // Writes during COMPUTE: edge 4 evaluates row 3
        accept(8'h01);
        tick();
        tick();
        tick();
        chk("mid busy", 32'(busy), 32'd1);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hF7;
        tick();
        wr_addr = 3'd1; wr_data = 8'hFD;
        tick();
        wr_addr = 3'd6; wr_data = 8'hBF;
        tick();
        wr_en = 1'b0;
        wait_done("mid", lat);
        chk("mid out",  32'(out_data),  32'hBF);
        chk("mid out7", 32'(out_data7), 32'h01);
        chk("mid out6", 32'(out_data6), 32'h3F);
        tick();
        run("after mid", 8'h01, 8'hB5, 8'h01, 6'h35);

        // Reset during COMPUTE
        accept(8'hF0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data",  32'(out_data),  32'd0);
        chk("midrst in_ready",  32'(in_ready),  32'd1);
        chk("midrst busy",      32'(busy),      32'd0);
        tick();
        reset = 1'b0;
        run("midrst x00", 8'h00, 8'hFF, 8'hFF, 6'h3F);
        run("midrst xFF", 8'hFF, 8'h00, 8'h00, 6'h00);

        // Thresholds: thr[3]=0 (with a simultaneous zero row write), thr[2]=9
        wr_en = 1'b1; thr_wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h00;
        tick();
        wr_en = 1'b0; wr_addr = 3'd2; wr_data = 8'h09;
        tick();
        thr_wr_en = 1'b0;
        run("thr xFF", 8'hFF,
            THR_PROG ? 8'h08 : 8'h00, THR_PROG ? 8'h08 : 8'h00, THR_PROG ? 6'h08 : 6'h00);
        run("thr x00", 8'h00,
            THR_PROG ? 8'hFB : 8'hFF, THR_PROG ? 8'hFB : 8'hFF, THR_PROG ? 6'h3B : 6'h3F);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
